// File: rtl/jogador_automatico.sv
// jogador_automatico: automated Genius player that watches leds, replays them on botoes and adds one new move
module jogador_automatico #(
  parameter int MAX_JOGADAS = 16,
  parameter int T_PRESS     = 10,
  parameter int T_GAP       = 10,
  parameter int T_SILENCIO  = 50
)(
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] leds,
  input  logic       pronto,
  input  logic       ganhou,
  input  logic       perdeu,
  output logic       jogar,
  output logic [3:0] botoes,
  output logic       ativo,
  output logic       erro_protocolo,
  output logic [3:0] db_estado,
  output logic [4:0] db_tamanho
);
  localparam int TM1 = T_PRESS > T_GAP ? T_PRESS : T_GAP;
  localparam int TMAX = TM1 > T_SILENCIO ? TM1 : T_SILENCIO;
  localparam int TW = $clog2(TMAX + 1);
  localparam int AW = $clog2(MAX_JOGADAS);
  localparam logic [TW-1:0] P_FIM = TW'(T_PRESS - 1);
  localparam logic [TW-1:0] G_FIM = TW'(T_GAP - 1);
  localparam logic [TW-1:0] S_FIM = TW'(T_SILENCIO - 1);
  localparam logic [4:0] MAXI = 5'(MAX_JOGADAS);
  typedef enum logic [2:0] {
    INICIAL, PULSO_JOGAR, OBSERVA, REPRODUZ_ATIVO,
    REPRODUZ_PAUSA, NOVA_ATIVA, NOVA_PAUSA, FIM
  } estado_t;
  estado_t state, state_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [4:0] idx, ridx;
  logic [1:0] cnt;
  logic [3:0] prev;
  logic [3:0] mem [MAX_JOGADAS];
  logic erro, cap, err, inc_r, clr_r, inc_c, clr_i, term, borda, parado;
  // next state, timer and bookkeeping strobes; termination outranks everything in active states
  always_comb begin
    term = pronto | ganhou | perdeu;
    borda = prev == 4'd0 && leds != 4'd0;
    parado = state == INICIAL || state == FIM;
    state_n = state;
    tmr_n = tmr + 1'b1;
    cap = 1'b0;
    err = 1'b0;
    inc_r = 1'b0;
    clr_r = 1'b0;
    inc_c = 1'b0;
    clr_i = 1'b0;
    if (parado) begin
      if (iniciar) begin
        state_n = PULSO_JOGAR;
        clr_i = 1'b1;
      end
    end else if (term) state_n = FIM;
    else case (state)
      PULSO_JOGAR: if (tmr == P_FIM) state_n = OBSERVA;
      OBSERVA: begin
        tmr_n = leds != 4'd0 ? '0 : tmr == S_FIM ? tmr : tmr + 1'b1;
        if (!$onehot0(leds) || (borda && idx == MAXI)) begin
          err = 1'b1;
          state_n = FIM;
        end else if (borda) cap = 1'b1;
        else if (leds == 4'd0 && tmr == S_FIM && idx != 5'd0) begin
          clr_r = 1'b1;
          state_n = REPRODUZ_ATIVO;
        end
      end
      REPRODUZ_ATIVO: if (tmr == P_FIM) state_n = REPRODUZ_PAUSA;
      REPRODUZ_PAUSA: if (tmr == G_FIM) begin
        inc_r = 1'b1;
        state_n = ridx + 5'd1 == idx ? NOVA_ATIVA : REPRODUZ_ATIVO;
      end
      NOVA_ATIVA: if (tmr == P_FIM) begin
        inc_c = 1'b1;
        state_n = NOVA_PAUSA;
      end
      NOVA_PAUSA: if (tmr == G_FIM) begin
        clr_i = 1'b1;
        state_n = OBSERVA;
      end
      default: ;
    endcase
  end
  // state, timers (cleared on every state change), indices and sticky error
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INICIAL;
      tmr <= '0;
      idx <= '0;
      ridx <= '0;
      cnt <= '0;
      prev <= '0;
      erro <= 1'b0;
    end else begin
      state <= state_n;
      tmr <= state_n != state ? '0 : tmr_n;
      prev <= leds;
      idx <= clr_i ? '0 : cap ? idx + 5'd1 : idx;
      ridx <= clr_r ? '0 : inc_r ? ridx + 5'd1 : ridx;
      cnt <= cnt + {1'b0, inc_c};
      erro <= err | (erro & ~(parado & iniciar));
    end
  end
  // sequence memory, contents need no reset
  always_ff @(posedge clock) begin
    if (!reset && cap) mem[idx[AW-1:0]] <= leds;
  end
  assign jogar = state == PULSO_JOGAR;
  assign botoes = state == REPRODUZ_ATIVO ? mem[ridx[AW-1:0]] : state == NOVA_ATIVA ? 4'b0001 << cnt : 4'd0;
  assign ativo = !parado;
  assign erro_protocolo = erro;
  assign db_estado = {1'b0, state};
  assign db_tamanho = idx;
endmodule

// File: doc/jogador_automatico.md
Name: jogador_automatico

Overview:
- Automated player for the Genius game core: the player-side end of the leds/botoes protocol.
- Watches the sequence the game shows on `leds`, stores it, replays it on `botoes` with fixed press/gap timing, then presses one new move.
- Starts the game by pulsing `jogar`; stops when the game reports `pronto`, `ganhou` or `perdeu`.
- Used in self-checking system benches and in the FPGA demo mode in place of the human player.

Parameters:
MAX_JOGADAS  16  depth of the sequence memory (moves per round)
T_PRESS  10  clock cycles each button press (and the `jogar` pulse) is held high
T_GAP  10  clock cycles of `botoes`=0000 after each press
T_SILENCIO  50  consecutive cycles of `leds`=0000 that end the display phase

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
iniciar  in  1  start request (level, sampled in INICIAL/FIM)
leds  in  4  game LED outputs (one-hot or 0000)
pronto  in  1  game finished
ganhou  in  1  game won
perdeu  in  1  game lost
jogar  out  1  start pulse to the game
botoes  out  4  button presses to the game (one-hot or 0000)
ativo  out  1  high in every state except INICIAL and FIM
erro_protocolo  out  1  sticky: illegal `leds` value or memory overflow
db_estado  out  4  current state code
db_tamanho  out  5  number of moves captured in the current round

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - state = INICIAL.
  - All outputs 0; memory contents don't-care.
  - Capture index, replay index, timers and new-move counter cleared to 0.
- All outputs are registered: a state change is visible on outputs one cycle after the triggering input edge.
- States and codes:
  - INICIAL (0): wait. `iniciar`=1 -> PULSO_JOGAR.
  - PULSO_JOGAR (1): `jogar`=1 for exactly T_PRESS cycles -> OBSERVA. Capture index and silence timer cleared on entry.
  - OBSERVA (2): capture and silence timing.
    - Capture on each 0000 -> nonzero transition of `leds`, using a registered previous value: mem[idx] <= leds, then idx++.
    - Holding a LED steady does not recapture.
    - Silence timer counts consecutive cycles of `leds`=0000 and resets on any nonzero `leds`.
    - Timer reaches T_SILENCIO with idx>0 -> REPRODUZ_ATIVO. With idx=0, keep waiting.
  - REPRODUZ_ATIVO (3): `botoes` = mem[ridx] for T_PRESS cycles -> REPRODUZ_PAUSA.
  - REPRODUZ_PAUSA (4): `botoes`=0000 for T_GAP cycles, then ridx++.
    - ridx = tamanho -> NOVA_ATIVA.
    - Otherwise -> REPRODUZ_ATIVO.
  - NOVA_ATIVA (5): `botoes` = one-hot of the 2-bit new-move counter (0 -> 0001, 1 -> 0010, 2 -> 0100, 3 -> 1000) for T_PRESS cycles -> NOVA_PAUSA. Counter increments on exit and wraps 3 -> 0.
  - NOVA_PAUSA (6): `botoes`=0000 for T_GAP cycles -> OBSERVA.
    - Capture index cleared: the game redisplays the full sequence each round, so memory is overwritten from index 0.
  - FIM (7): `botoes`=0000, `jogar`=0. `iniciar`=1 -> PULSO_JOGAR, with `erro_protocolo` cleared.
- Termination: `pronto`, `ganhou` or `perdeu` high in any state other than INICIAL/FIM -> FIM on the next edge. `botoes` drops to 0000 the same edge; an in-progress press is abandoned.
- Errors (both go to FIM):
  - In OBSERVA, `leds` not in {0000, 0001, 0010, 0100, 1000} -> `erro_protocolo`=1.
  - A capture with idx=MAX_JOGADAS -> `erro_protocolo`=1; nothing is written.
- `leds` activity outside OBSERVA is ignored.
- `db_tamanho` = capture index, range 0..MAX_JOGADAS. Timers are sized for the larger of T_PRESS, T_GAP and T_SILENCIO.
- Simultaneous events:
  - Termination beats timer expiry and beats capture.
  - Error beats capture.
  - In INICIAL/FIM, `iniciar` is sampled only when the termination inputs are ignored.

Test Plan:
- Reset then `iniciar`=1 for 1 cycle -> `jogar`=1 for exactly 10 cycles, then state=2. All outputs are 0 during reset.
- Game model shows 0001 for 5 cycles, then 0000 for 50 cycles -> `db_tamanho`=1. Then `botoes`=0001 for 10 cycles, 0000 for 10, 0001 for 10 (new move, counter=0), 0000 for 10, state back to 2.
- Round 2: display 0001, 0010, 0010 with gaps -> `db_tamanho`=3. Replay 0001, 0010, 0010, then new move 0010 (counter=1).
- `leds`=0101 during OBSERVA -> `erro_protocolo`=1, state=7, `botoes`=0000. A later `iniciar` clears the error and re-pulses `jogar`.
- 17 LED pulses with MAX_JOGADAS=16 -> `erro_protocolo`=1 on the 17th pulse, `db_tamanho`=16.
- `perdeu`=1 mid-press (`botoes`=0100) -> next cycle `botoes`=0000, state=7, `ativo`=0. Reset asserted mid-replay -> all outputs 0 on the next edge.
